// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: one-hot FSM states and frame constants.
package uart_rx_pkg;

  localparam int unsigned DataBits   = 8;
  localparam logic        StartLevel = 1'b0;
  localparam logic        StopLevel  = 1'b1;

  typedef enum logic [3:0] {
    RxIdle  = 4'b0001,
    RxStart = 4'b0010,
    RxData  = 4'b0100,
    RxStop  = 4'b1000
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop RxD synchroniser (reset to idle-high) with synchronised falling-edge detect.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rxd_i,
  output logic line_s,
  output logic fall_s
);

  logic       s1_q, s2_q, prev_q;
  logic [1:0] fill_q;
  logic       armed_q;

  // Edge detect stays disarmed until the synchroniser holds a real post-reset high,
  // so a line that is already low when reset releases never fakes a start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      prev_q  <= 1'b1;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      s1_q   <= rxd_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      fill_q <= {fill_q[0], 1'b1};
      if (fill_q[1] && s2_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign line_s = s2_q;
  assign fall_s = armed_q & prev_q & ~s2_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, MSB first, fixed CLKS_PER_BIT oversampling.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote around mid-bit, all decisions one cycle later.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       RxD_i,
  input  logic       rd_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       rx_full_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       RX_busy_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned Half = CLKS_PER_BIT / 2;
  localparam logic [CntW-1:0] BitLast = CntW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CntW-1:0] StartLast = CntW'(Half);
`else
  localparam logic [CntW-1:0] StartLast = CntW'(Half - 1);
`endif

  logic line_s, fall_s, bit_s;

  uart_rx_sync u_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .rxd_i  (RxD_i),
    .line_s (line_s),
    .fall_s (fall_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // hist_q[1] = mid-1, hist_q[0] = mid, line_s = mid+1 at decision time
  logic [1:0] hist_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], line_s};
    end
  end
  assign bit_s = maj3(hist_q[1], hist_q[0], line_s);
`else
  assign bit_s = line_s;
`endif

  rx_state_e           state_q;
  logic [CntW-1:0]     cnt_q;
  logic [2:0]          bit_cnt_q;
  logic [DataBits-1:0] shift_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RxIdle;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      rx_full_o   <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      RX_busy_o   <= 1'b0;
    end else begin
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      if (rd_i) begin
        rx_full_o <= 1'b0;
      end
      unique case (state_q)
        RxIdle: begin
          if (fall_s) begin
            state_q   <= RxStart;
            cnt_q     <= '0;
            RX_busy_o <= 1'b1;
          end
        end
        RxStart: begin
          if (cnt_q == StartLast) begin
            cnt_q <= '0;
            if (bit_s == StartLevel) begin
              state_q   <= RxData;
              bit_cnt_q <= '0;
            end else begin
              state_q   <= RxIdle;
              RX_busy_o <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        RxData: begin
          if (cnt_q == BitLast) begin
            cnt_q     <= '0;
            shift_q   <= {shift_q[DataBits-2:0], bit_s};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'(DataBits - 1)) begin
              state_q <= RxStop;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        RxStop: begin
          // Leave at mid-stop so a back-to-back start edge is not missed
          if (cnt_q == BitLast) begin
            cnt_q     <= '0;
            state_q   <= RxIdle;
            RX_busy_o <= 1'b0;
            if (bit_s == StopLevel) begin
              data_o    <= shift_q;
              valid_o   <= 1'b1;
              rx_full_o <= 1'b1;
              overrun_o <= rx_full_o & ~rd_i;
            end else begin
              frame_err_o <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q   <= RxIdle;
          RX_busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames vs a frame-level model.
module tb_uart_rx;

  localparam int unsigned N = 16;
  localparam int unsigned H = N / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned Lat = 3 + H + 9 * N + 1;
`else
  localparam int unsigned Lat = 3 + H + 9 * N;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       rxd   = 1'b1;
  logic       rd    = 1'b0;
  logic [7:0] data_o;
  logic       valid_o, rx_full_o, frame_err_o, overrun_o, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Event monitor
  int         n_valid   = 0;
  int         n_ferr    = 0;
  int         n_ovr     = 0;
  int         last_vcyc = -1;
  logic [7:0] last_vdata = 8'h00;

  // Reference model state
  logic [7:0] exp_data  = 8'h00;
  logic       exp_full  = 1'b0;
  int         exp_valid = 0;
  int         exp_ferr  = 0;
  int         exp_ovr   = 0;

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .RxD_i       (rxd),
    .rd_i        (rd),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .rx_full_o   (rx_full_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .RX_busy_o   (busy)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (valid_o) begin
      n_valid    <= n_valid + 1;
      last_vdata <= data_o;
      last_vcyc  <= cyc;
    end
    if (frame_err_o) n_ferr <= n_ferr + 1;
    if (overrun_o)   n_ovr  <= n_ovr + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic do_read();
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    exp_full = 1'b0;
  endtask

  // Sends one frame starting right after the current edge; e returns that edge's index.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic rd_early,
                            input logic rd_done, output int e);
    e   = cyc;
    rxd = 1'b0;
    rd  = rd_early;
    tick(1);
    rd = 1'b0;
    tick(N - 1);
    for (int i = 7; i >= 0; i--) begin
      rxd = b[i];
      tick(N);
    end
    rxd = stop;
    if (rd_done) begin
      tick(Lat - 9 * N - 1);
      rd = 1'b1;
      tick(1);
      rd = 1'b0;
      tick(10 * N - Lat);
    end else begin
      tick(N);
    end
    rxd = 1'b1;
    if (rd_early) exp_full = 1'b0;
    if (stop) begin
      exp_valid++;
      if (exp_full && !rd_done) exp_ovr++;
      exp_data = b;
      exp_full = 1'b1;
    end else begin
      exp_ferr++;
      if (rd_done) exp_full = 1'b0;
    end
  endtask

  task automatic test_reset();
    tick(3);
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL rst_data got %0h want 0", data_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", valid_o); end
    checks++; if (rx_full_o !== 1'b0) begin errors++; $display("FAIL rst_full got %b want 0", rx_full_o); end
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL rst_ferr got %b want 0", frame_err_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL rst_ovr got %b want 0", overrun_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    rst_i = 1'b0;
    tick(6);
  endtask

  task automatic test_single_byte();
    int e;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, e);
    checks++; if (last_vcyc !== e + Lat) begin
      errors++; $display("FAIL sb_latency got %0d want %0d", last_vcyc - e, Lat); end
    checks++; if (n_valid !== exp_valid) begin
      errors++; $display("FAIL sb_valid_count got %0d want %0d", n_valid, exp_valid); end
    checks++; if (last_vdata !== 8'hA5) begin
      errors++; $display("FAIL sb_vdata got %0h want a5", last_vdata); end
    checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL sb_data got %0h want a5", data_o); end
    checks++; if (rx_full_o !== 1'b1) begin errors++; $display("FAIL sb_full got %b want 1", rx_full_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sb_busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int e;
    do_read();
    send_frame(8'h00, 1'b1, 1'b0, 1'b0, e);
    checks++; if (last_vdata !== 8'h00) begin
      errors++; $display("FAIL b2b_first got %0h want 00", last_vdata); end
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0, e);
    checks++; if (last_vdata !== 8'hFF) begin
      errors++; $display("FAIL b2b_second got %0h want ff", last_vdata); end
    checks++; if (n_valid !== exp_valid) begin
      errors++; $display("FAIL b2b_valid_count got %0d want %0d", n_valid, exp_valid); end
    checks++; if (n_ferr !== exp_ferr) begin
      errors++; $display("FAIL b2b_ferr got %0d want %0d", n_ferr, exp_ferr); end
    checks++; if (n_ovr !== exp_ovr) begin
      errors++; $display("FAIL b2b_ovr got %0d want %0d", n_ovr, exp_ovr); end
  endtask

  task automatic test_false_start();
    int e;
    rxd = 1'b0;
    tick(4);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fs_busy_start got %b want 1", busy); end
    rxd = 1'b1;
    tick(3 * N);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fs_busy_idle got %b want 0", busy); end
    checks++; if (n_valid !== exp_valid) begin
      errors++; $display("FAIL fs_valid got %0d want %0d", n_valid, exp_valid); end
    checks++; if (n_ferr !== exp_ferr) begin
      errors++; $display("FAIL fs_ferr got %0d want %0d", n_ferr, exp_ferr); end
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, e);
    checks++; if (data_o !== 8'h3C) begin errors++; $display("FAIL fs_next got %0h want 3c", data_o); end
  endtask

  task automatic test_frame_error();
    int e;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, e);
    tick(N);
    checks++; if (n_ferr !== exp_ferr) begin
      errors++; $display("FAIL fe_count got %0d want %0d", n_ferr, exp_ferr); end
    checks++; if (n_valid !== exp_valid) begin
      errors++; $display("FAIL fe_valid got %0d want %0d", n_valid, exp_valid); end
    checks++; if (data_o !== exp_data) begin
      errors++; $display("FAIL fe_data got %0h want %0h", data_o, exp_data); end
    checks++; if (rx_full_o !== exp_full) begin
      errors++; $display("FAIL fe_full got %b want %b", rx_full_o, exp_full); end
  endtask

  task automatic test_overrun();
    int e;
    do_read();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, e);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, e);
    checks++; if (n_ovr !== exp_ovr) begin
      errors++; $display("FAIL ovr_count got %0d want %0d", n_ovr, exp_ovr); end
    checks++; if (data_o !== 8'h22) begin errors++; $display("FAIL ovr_data got %0h want 22", data_o); end
    send_frame(8'h33, 1'b1, 1'b0, 1'b1, e);
    checks++; if (n_ovr !== exp_ovr) begin
      errors++; $display("FAIL simrd_ovr got %0d want %0d", n_ovr, exp_ovr); end
    checks++; if (rx_full_o !== 1'b1) begin
      errors++; $display("FAIL simrd_full got %b want 1", rx_full_o); end
    checks++; if (data_o !== 8'h33) begin errors++; $display("FAIL simrd_data got %0h want 33", data_o); end
  endtask

  task automatic test_reset_mid_frame();
    int e;
    rxd = 1'b0;                       // start + data bits 0..4 of 0x00, abort mid bit 4
    tick(N + 4 * N + H);
    rst_i = 1'b1;
    tick(3);
    rst_i = 1'b0;
    exp_full = 1'b0;
    exp_data = 8'h00;
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL rmf_data got %0h want 0", data_o); end
    checks++; if (rx_full_o !== 1'b0) begin errors++; $display("FAIL rmf_full got %b want 0", rx_full_o); end
    tick(2 * N);                      // line still low: must not look like a start
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmf_busy got %b want 0", busy); end
    rxd = 1'b1;
    tick(N);
    checks++; if (n_valid !== exp_valid) begin
      errors++; $display("FAIL rmf_valid got %0d want %0d", n_valid, exp_valid); end
    checks++; if (n_ferr !== exp_ferr) begin
      errors++; $display("FAIL rmf_ferr got %0d want %0d", n_ferr, exp_ferr); end
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, e);
    checks++; if (data_o !== 8'h5A) begin errors++; $display("FAIL rmf_next got %0h want 5a", data_o); end
    checks++; if (rx_full_o !== 1'b1) begin errors++; $display("FAIL rmf_full2 got %b want 1", rx_full_o); end
  endtask

  task automatic test_random();
    int         e;
    logic [7:0] b;
    logic       stop, rde, rdd;
    for (int k = 0; k < 10; k++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      rde  = 1'($urandom_range(0, 1));
      rdd  = 1'($urandom_range(0, 1));
      send_frame(b, stop, rde, rdd, e);
      tick(stop ? int'($urandom_range(0, N)) : N);
      checks++; if (n_valid !== exp_valid || last_vdata !== exp_data) begin
        errors++; $display("FAIL rnd_valid[%0d] got %0d/%0h want %0d/%0h", k, n_valid,
                           last_vdata, exp_valid, exp_data); end
      checks++; if (data_o !== exp_data) begin
        errors++; $display("FAIL rnd_data[%0d] got %0h want %0h", k, data_o, exp_data); end
      checks++; if (rx_full_o !== exp_full) begin
        errors++; $display("FAIL rnd_full[%0d] got %b want %b", k, rx_full_o, exp_full); end
      checks++; if (n_ferr !== exp_ferr || n_ovr !== exp_ovr) begin
        errors++; $display("FAIL rnd_err[%0d] got %0d/%0d want %0d/%0d", k, n_ferr, n_ovr,
                           exp_ferr, exp_ovr); end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_false_start();
    test_frame_error();
    test_overrun();
    test_reset_mid_frame();
    test_random();
    tick(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
